// File: rtl/rsp_s2_prep_ahbic_pkg.sv
// Shared AHB interconnect definitions for the rsp_s2_prep bus matrix:
// transfer/burst codes and the burst-length helper used by the MI arbiters.
package rsp_s2_prep_ahbic_pkg;

  localparam int NUM_SI = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Beats remaining after the NONSEQ; undefined-length INCR behaves like SINGLE.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:  beats = 4'd0;
      HBURST_WRAP4, HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                     beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/rsp_s2_prep_ahbic_arb_mi_if.sv
// Request/response bundle between the SI stages and one MI-port arbiter.
interface rsp_s2_prep_ahbic_arb_mi_if;
  import rsp_s2_prep_ahbic_pkg::*;

  logic                  HREADYM;
  logic [NUM_SI-1:0]     req_in;
  logic [2*NUM_SI-1:0]   trans_in;
  logic [3*NUM_SI-1:0]   burst_in;
  logic [NUM_SI-1:0]     lock_in;
  logic [1:0]            addr_in_port;
  logic                  no_port;
  logic [1:0]            data_in_port;
  logic                  data_valid;
  logic [NUM_SI-1:0]     active_out;

  modport slave (
    input  HREADYM, req_in, trans_in, burst_in, lock_in,
    output addr_in_port, no_port, data_in_port, data_valid, active_out
  );

  modport master (
    output HREADYM, req_in, trans_in, burst_in, lock_in,
    input  addr_in_port, no_port, data_in_port, data_valid, active_out
  );

endinterface

// File: rtl/rsp_s2_prep_ahbic_rr_pick.sv
// Combinational 3-way round-robin picker: first set request after 'last'.
module rsp_s2_prep_ahbic_rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       any
);

  // Search order rotates so the previous winner has lowest priority.
  always_comb begin
    idx = 2'd0;
    any = |req;
    case (last)
      2'd0: begin
        if (req[1])      idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else             idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      idx = 2'd2;
        else if (req[0]) idx = 2'd0;
        else             idx = 2'd1;
      end
      default: begin
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else             idx = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/rsp_s2_prep_ahbic_arb_mi.sv
// MI-port output-stage arbiter: round-robin grant among three SI stages,
// held across defined-length bursts and locked sequences.
module rsp_s2_prep_ahbic_arb_mi
  import rsp_s2_prep_ahbic_pkg::*;
#(
  parameter logic [1:0] DFLT_SI = 2'd0
) (
  input logic                        HCLK,
  input logic                        HRESETn,
  rsp_s2_prep_ahbic_arb_mi_if.slave  bus
);

  logic [1:0]        addr_in_port_r;
  logic              no_port_r;
  logic [1:0]        data_in_port_r;
  logic              data_valid_r;
  logic [3:0]        beat_cnt_r;
  logic [1:0]        last_r;

  logic [3:0]        beat_cnt_s;
  logic [1:0]        own_trans_s;
  logic [2:0]        own_burst_s;
  logic              own_lock_s;
  logic              hold_s;
  logic [1:0]        pick_idx_s;
  logic              pick_any_s;
  logic [NUM_SI-1:0] active_s;

  rsp_s2_prep_ahbic_rr_pick u_pick (
    .req  (bus.req_in),
    .last (last_r),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Select the current address-phase owner's transfer attributes.
  always_comb begin
    own_trans_s = HTRANS_IDLE;
    own_burst_s = HBURST_SINGLE;
    own_lock_s  = 1'b0;
    case (addr_in_port_r)
      2'd0: begin
        own_trans_s = bus.trans_in[1:0];
        own_burst_s = bus.burst_in[2:0];
        own_lock_s  = bus.lock_in[0];
      end
      2'd1: begin
        own_trans_s = bus.trans_in[3:2];
        own_burst_s = bus.burst_in[5:3];
        own_lock_s  = bus.lock_in[1];
      end
      2'd2: begin
        own_trans_s = bus.trans_in[5:4];
        own_burst_s = bus.burst_in[8:6];
        own_lock_s  = bus.lock_in[2];
      end
      default: begin
        own_trans_s = HTRANS_IDLE;
        own_burst_s = HBURST_SINGLE;
        own_lock_s  = 1'b0;
      end
    endcase
  end

  // Beat counter update; hold looks at the count after this beat so a
  // burst's own NONSEQ already keeps the grant.
  always_comb begin
    beat_cnt_s = beat_cnt_r;
    if (bus.HREADYM && !no_port_r) begin
      case (own_trans_s)
        HTRANS_IDLE:   beat_cnt_s = 4'd0;
        HTRANS_NONSEQ: beat_cnt_s = burst_beats(own_burst_s);
        HTRANS_SEQ:    beat_cnt_s = (beat_cnt_r != 4'd0) ? beat_cnt_r - 4'd1 : 4'd0;
        default:       beat_cnt_s = beat_cnt_r;
      endcase
    end else begin
      beat_cnt_s = beat_cnt_r;
    end
    hold_s = (beat_cnt_s != 4'd0) | (~no_port_r & own_lock_s);
  end

  // Owner, data-phase and burst state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port_r <= DFLT_SI;
      no_port_r      <= 1'b1;
      data_in_port_r <= 2'd0;
      data_valid_r   <= 1'b0;
      beat_cnt_r     <= 4'd0;
      last_r         <= 2'd2;
    end else begin
      beat_cnt_r <= beat_cnt_s;
      if (bus.HREADYM) begin
        data_in_port_r <= addr_in_port_r;
        data_valid_r   <= ~no_port_r & own_trans_s[1];
        if (!hold_s) begin
          if (pick_any_s) begin
            addr_in_port_r <= pick_idx_s;
            no_port_r      <= 1'b0;
            last_r         <= pick_idx_s;
          end else begin
            no_port_r      <= 1'b1;
          end
        end
      end
    end
  end

  // One-hot owner flag decoded from registered state only.
  always_comb begin
    active_s = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      active_s[i] = ~no_port_r & (addr_in_port_r == 2'(i));
    end
  end

  assign bus.addr_in_port = addr_in_port_r;
  assign bus.no_port      = no_port_r;
  assign bus.data_in_port = data_in_port_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.active_out   = active_s;

endmodule

// File: tb/tb_rsp_s2_prep_ahbic_arb_mi.sv
// Directed bench for the MI arbiter: reset, round-robin, bursts, lock, reset mid-burst.
module tb_rsp_s2_prep_ahbic_arb_mi;

  localparam logic [1:0] T_I = 2'b00;
  localparam logic [1:0] T_B = 2'b01;
  localparam logic [1:0] T_N = 2'b10;
  localparam logic [1:0] T_Q = 2'b11;
  localparam logic [2:0] B_S   = 3'b000;
  localparam logic [2:0] B_I4  = 3'b011;
  localparam logic [2:0] B_W8  = 3'b100;
  localparam logic [2:0] B_I16 = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail = 0;

  rsp_s2_prep_ahbic_arb_mi_if bus();

  rsp_s2_prep_ahbic_arb_mi #(.DFLT_SI(2'd0)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] tr(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    return {t2, t1, t0};
  endfunction

  function automatic logic [8:0] bu(input logic [2:0] b0, input logic [2:0] b1, input logic [2:0] b2);
    return {b2, b1, b0};
  endfunction

  task automatic drive(input logic [2:0] req, input logic [5:0] trans, input logic [8:0] burst,
                       input logic [2:0] lock, input logic rdy);
    bus.req_in   = req;
    bus.trans_in = trans;
    bus.burst_in = burst;
    bus.lock_in  = lock;
    bus.HREADYM  = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and idle
    rst_n = 1'b0;
    drive(3'b000, tr(T_I, T_I, T_I), bu(B_S, B_S, B_S), 3'b000, 1'b1);
    #22;
    rst_n = 1'b1;
    #1;
    chk("rst_no_port", {7'd0, bus.no_port}, 8'd1);
    chk("rst_active", {5'd0, bus.active_out}, 8'd0);
    chk("rst_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("rst_dvalid", {7'd0, bus.data_valid}, 8'd0);
    chk("rst_dport", {6'd0, bus.data_in_port}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_no_port", {7'd0, bus.no_port}, 8'd1);
      chk("idle_addr", {6'd0, bus.addr_in_port}, 8'd0);
    end

    // 2: all request SINGLE, grant rotates 0,1,2,0
    drive(3'b111, tr(T_N, T_N, T_N), bu(B_S, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("rr0_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("rr0_active", {5'd0, bus.active_out}, 8'b001);
    chk("rr0_no_port", {7'd0, bus.no_port}, 8'd0);
    chk("rr0_dvalid", {7'd0, bus.data_valid}, 8'd0);
    step();
    chk("rr1_addr", {6'd0, bus.addr_in_port}, 8'd1);
    chk("rr1_active", {5'd0, bus.active_out}, 8'b010);
    chk("rr1_dport", {6'd0, bus.data_in_port}, 8'd0);
    chk("rr1_dvalid", {7'd0, bus.data_valid}, 8'd1);
    step();
    chk("rr2_addr", {6'd0, bus.addr_in_port}, 8'd2);
    chk("rr2_active", {5'd0, bus.active_out}, 8'b100);
    chk("rr2_dport", {6'd0, bus.data_in_port}, 8'd1);
    step();
    chk("rr3_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("rr3_active", {5'd0, bus.active_out}, 8'b001);
    chk("rr3_dport", {6'd0, bus.data_in_port}, 8'd2);

    // 3: SI1 INCR4 holds four beats while SI0/SI2 wait
    drive(3'b111, tr(T_N, T_N, T_N), bu(B_S, B_I4, B_S), 3'b000, 1'b1);
    step();
    chk("i4_grant", {6'd0, bus.addr_in_port}, 8'd1);
    step();
    chk("i4_nonseq", {6'd0, bus.addr_in_port}, 8'd1);
    chk("i4_dport", {6'd0, bus.data_in_port}, 8'd1);
    drive(3'b111, tr(T_N, T_Q, T_N), bu(B_S, B_I4, B_S), 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("i4_seq_addr", {6'd0, bus.addr_in_port}, (i == 2) ? 8'd2 : 8'd1);
    end

    // 4: SI0 WRAP8 with BUSY beats and wait states
    drive(3'b111, tr(T_N, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("w8_grant", {6'd0, bus.addr_in_port}, 8'd0);
    chk("w8_idle_dvalid", {7'd0, bus.data_valid}, 8'd0);
    chk("w8_idle_dport", {6'd0, bus.data_in_port}, 8'd2);
    step();
    chk("w8_nonseq_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("w8_nonseq_dvalid", {7'd0, bus.data_valid}, 8'd1);
    drive(3'b111, tr(T_Q, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("w8_seq1", {6'd0, bus.addr_in_port}, 8'd0);
    drive(3'b111, tr(T_B, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("w8_busy_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("w8_busy_dvalid", {7'd0, bus.data_valid}, 8'd0);
    drive(3'b111, tr(T_Q, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w8_wait_addr", {6'd0, bus.addr_in_port}, 8'd0);
      chk("w8_wait_dvalid", {7'd0, bus.data_valid}, 8'd0);
    end
    bus.HREADYM = 1'b1;
    step();
    chk("w8_seq2_dvalid", {7'd0, bus.data_valid}, 8'd1);
    drive(3'b111, tr(T_B, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("w8_busy2_addr", {6'd0, bus.addr_in_port}, 8'd0);
    drive(3'b111, tr(T_Q, T_I, T_I), bu(B_W8, B_S, B_S), 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("w8_tail_addr", {6'd0, bus.addr_in_port}, (i == 4) ? 8'd1 : 8'd0);
    end
    chk("w8_end_dport", {6'd0, bus.data_in_port}, 8'd0);
    chk("w8_end_dvalid", {7'd0, bus.data_valid}, 8'd1);

    // 5: SI2 locked across three SINGLEs and a trailing IDLE
    drive(3'b101, tr(T_N, T_I, T_N), bu(B_S, B_S, B_S), 3'b100, 1'b1);
    step();
    chk("lk_grant", {6'd0, bus.addr_in_port}, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lk_single_addr", {6'd0, bus.addr_in_port}, 8'd2);
    end
    drive(3'b101, tr(T_N, T_I, T_I), bu(B_S, B_S, B_S), 3'b100, 1'b1);
    step();
    chk("lk_idle_addr", {6'd0, bus.addr_in_port}, 8'd2);
    drive(3'b001, tr(T_N, T_I, T_I), bu(B_S, B_S, B_S), 3'b000, 1'b0);
    step();
    chk("lk_wait_addr", {6'd0, bus.addr_in_port}, 8'd2);
    bus.HREADYM = 1'b1;
    step();
    chk("lk_release_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("lk_release_active", {5'd0, bus.active_out}, 8'b001);

    // 6: reset during beat 2 of INCR16
    drive(3'b001, tr(T_N, T_I, T_I), bu(B_I16, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("i16_nonseq_dvalid", {7'd0, bus.data_valid}, 8'd1);
    drive(3'b111, tr(T_Q, T_N, T_N), bu(B_I16, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("i16_beat2_addr", {6'd0, bus.addr_in_port}, 8'd0);
    chk("i16_beat2_cnt", {4'd0, dut.beat_cnt_r}, 8'd14);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_no_port", {7'd0, bus.no_port}, 8'd1);
    chk("arst_dvalid", {7'd0, bus.data_valid}, 8'd0);
    chk("arst_active", {5'd0, bus.active_out}, 8'd0);
    chk("arst_cnt", {4'd0, dut.beat_cnt_r}, 8'd0);
    step();
    chk("arst_hold_no_port", {7'd0, bus.no_port}, 8'd1);
    rst_n = 1'b1;
    drive(3'b111, tr(T_N, T_N, T_N), bu(B_S, B_S, B_S), 3'b000, 1'b1);
    step();
    chk("post_rst_first", {6'd0, bus.addr_in_port}, 8'd0);
    chk("post_rst_active", {5'd0, bus.active_out}, 8'b001);
    step();
    chk("post_rst_second", {6'd0, bus.addr_in_port}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
